instr_aligner: RTL and testbench
================================

Name: instr_aligner

Overview:
- Sits directly downstream of the one-deep fetch data buffer in the IF stage.
- Pops aligned 64-bit fetch words from that buffer and splits them into individual RV64 instructions, either 32-bit or 16-bit RVC.
- Tracks the PC of each instruction.
- Presents one instruction per cycle to decode over a valid/ready handshake.

Parameters:
- DataWidth, 64, fetch word width; only 64 is supported (4 halfwords per word).
- PcWidth, 64, PC width.
- ResetPc, 64'h8000_0000, PC of the first instruction after reset.

Ports:
- Clk  input  1  clock; all state on rising edge.
- Rst  input  1  synchronous, active-high reset.
- BufFull  input  1  fetch buffer holds a word (buffer full flag).
- BufData  input  DataWidth  buffer read data; valid only while BufPop=1.
- BufPop  output  1  pop strobe, asserted in the same cycle BufData is consumed.
- FlushValid  input  1  redirect from branch/exception unit.
- FlushPc  input  PcWidth  redirect target; bit 0 is ignored.
- InstValid  output  1  Inst/InstPc valid.
- InstReady  input  1  decode accepts the instruction.
- Inst  output  32  instruction; for RVC, the upper 16 bits are zero.
- InstPc  output  PcWidth  PC of Inst.
- InstIsRvc  output  1  Inst is 16-bit.

Behaviour:
- Reset (Rst=1 at edge):
  - Window empty (HwCnt=0), DropCnt=0, NextPc=ResetPc.
  - InstValid=0, Inst=0, InstPc=0, InstIsRvc=0.
  - BufPop is combinational and is 0 while Rst=1.
- Window:
  - Holds up to 5 halfwords, shift register, oldest at hw0. HwCnt counts 0..5.
  - Incoming words append at position HwCnt − consumed.
- Instruction completeness:
  - Complete when HwCnt≥1 and hw0[1:0]!=2'b11 (RVC, length 1).
  - Also complete when HwCnt≥2 and hw0[1:0]==2'b11 (32-bit, length 2).
- Issue: when a complete instruction exists and (InstValid=0 or InstReady=1), at the edge:
  - The output register loads Inst/InstIsRvc and InstPc=NextPc, and sets InstValid=1.
  - The window shifts by the instruction length; NextPc advances by 2 or 4.
  - Consumed this cycle = that length, otherwise 0.
  - If InstValid=1, InstReady=1 and nothing is complete, InstValid clears.
  - If InstValid=1 and InstReady=0, all outputs hold stable.
- Pop:
  - BufPop = BufFull & ~FlushValid & (HwCnt − consumed ≤ 1).
  - On pop, halfwords DropCnt..3 of BufData are appended and DropCnt clears to 0.
  - Per-cycle HwCnt update = HwCnt − consumed + (4 − DropCnt) on pop, otherwise HwCnt − consumed. It never exceeds 5.
- Latency:
  - A word popped in cycle N can produce InstValid=1 in cycle N+1 (loaded at the N edge), provided the output register is free.
  - Steady state with InstReady=1: one instruction per cycle, no bubbles for all-32-bit streams.
- Flush (highest priority, overrides issue and pop in the same cycle):
  - At the edge: HwCnt=0, InstValid=0, NextPc={FlushPc[PcWidth-1:1],1'b0}, DropCnt=FlushPc[2:1].
  - The buffer word present during a flush cycle is not popped; the upstream stage discards it.
- Split instruction:
  - A 32-bit instruction whose upper halfword is in the next word waits with HwCnt=1 until that word is popped.
  - No output is produced meanwhile.
- Boundary rules:
  - HwCnt=5 can only arise as a leftover halfword plus a full word; pop is then blocked until consumption.
  - Simultaneous pop and issue in one cycle is legal and must be handled.
  - NextPc wraps modulo 2^PcWidth.
  - Reset asserted mid-stream discards everything, identical to power-on reset.

Test Plan:
- Reset, then BufFull=1 with words {32'h00000513, 32'h00100593}, InstReady=1 -> InstValid rises one cycle after the pop; issues 0x00000513 @80000000, then 0x00100593 @80000004; BufPop high in the pop cycle only.
- Word 64'h0001_4501_0505_0001 (four RVC halfwords) -> four instructions with InstIsRvc=1: 0x0001, 0x0505, 0x4501, 0x0001 at PCs +0, +2, +4, +6; one per cycle.
- Straddle: word0 = three RVC halfwords + lower half 0x0513 of a 32-bit instruction, word1 starts with 0x0000 -> Inst=0x00000513 at PC 80000006; output holds while HwCnt=1 until word1 is popped.
- Backpressure: InstReady=0 for 3 cycles with InstValid=1 -> Inst/InstPc stable; BufPop=0 once HwCnt−consumed>1; resumes with no loss or duplication.
- FlushValid=1, FlushPc=0x80001006, while InstValid=1 and BufFull=1 -> next cycle InstValid=0, no pop in the flush cycle; next word drops hw0..hw2 and the first issued PC is 0x80001006.
- Rst=1 mid-stream for one cycle with HwCnt=3 -> all outputs 0; first issued PC is 80000000.

Source files
------------

// File: rtl/instr_aligner.sv
// -----------------------------------------------------------------------------
// instr_aligner
//
// Instruction aligner that sits directly behind the one-deep fetch buffer in
// the IF stage. It pops aligned 64-bit fetch words, splits them into RV64
// instructions (32-bit or 16-bit RVC), tracks each instruction's PC and hands
// one instruction per cycle to decode over a valid/ready handshake.
//
// Ports:
//   Clk         clock, all state updates on the rising edge
//   Rst         synchronous active-high reset
//   BufFull     fetch buffer holds a word
//   BufData     fetch buffer read data (consumed when BufPop=1)
//   BufPop      combinational pop strobe to the fetch buffer
//   FlushValid  redirect request from the branch/exception unit
//   FlushPc     redirect target (bit 0 ignored)
//   InstValid   Inst/InstPc/InstIsRvc are valid
//   InstReady   decode accepts the presented instruction
//   Inst        instruction (upper 16 bits zero for RVC)
//   InstPc      PC of Inst
//   InstIsRvc   Inst is a 16-bit compressed instruction
// -----------------------------------------------------------------------------
module instr_aligner #(
    parameter int unsigned          DataWidth = 64,
    parameter int unsigned          PcWidth   = 64,
    parameter logic [PcWidth-1:0]   ResetPc   = PcWidth'(64'h8000_0000)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 BufFull,
    input  logic [DataWidth-1:0] BufData,
    output logic                 BufPop,
    input  logic                 FlushValid,
    input  logic [PcWidth-1:0]   FlushPc,
    output logic                 InstValid,
    input  logic                 InstReady,
    output logic [31:0]          Inst,
    output logic [PcWidth-1:0]   InstPc,
    output logic                 InstIsRvc
);

    localparam int WordHw = 4;  // halfwords per fetch word
    localparam int WinHw  = 5;  // window capacity: one leftover + one full word
    localparam int MrgHw  = 7;  // window plus a word appended behind up to 3 leftovers

    // Window state: oldest halfword at index 0.
    logic [15:0]        win_q [WinHw];
    logic [2:0]         hw_cnt_q;
    logic [1:0]         drop_q;
    logic [PcWidth-1:0] next_pc_q;

    logic [15:0] buf_hw [WordHw];

    // Window-only view, used to decide the pop without depending on BufData.
    logic       win_rvc;
    logic       win_cmpl;
    logic       out_free;
    logic [2:0] cons_w;
    logic [2:0] rem_w;
    logic       pop;

    // Merged view: window followed by the word being popped this cycle.
    logic [15:0] mrg [MrgHw];
    logic [3:0]  mrg_cnt;
    logic [3:0]  src;
    logic        mrg_rvc;
    logic        mrg_cmpl;
    logic        issue;
    logic [1:0]  cons;
    logic [2:0]  hw_cnt_nx;
    logic [15:0] win_nx [WinHw];
    logic [31:0] inst_nx;

    logic flush_pc_unused;
    assign flush_pc_unused = FlushPc[0];

    always_comb begin
        for (int k = 0; k < WordHw; k++) begin
            buf_hw[k] = BufData[16*k +: 16];
        end
    end

    // The pop decision only looks at what the window itself can issue. When
    // the window has no complete instruction it holds at most one halfword,
    // so the pop condition is already met and the loop through BufData is
    // broken without changing the result.
    assign win_rvc  = (win_q[0][1:0] != 2'b11);
    assign win_cmpl = win_rvc ? (hw_cnt_q >= 3'd1) : (hw_cnt_q >= 3'd2);
    assign out_free = !InstValid || InstReady;
    assign cons_w   = (win_cmpl && out_free) ? (win_rvc ? 3'd1 : 3'd2) : 3'd0;
    assign rem_w    = hw_cnt_q - cons_w;
    assign pop      = BufFull && !FlushValid && !Rst && (rem_w <= 3'd1);
    assign BufPop   = pop;

    // Incoming halfwords DropCnt..3 land directly behind the valid window
    // contents, so an instruction can issue straight out of the popped word.
    always_comb begin
        src = 4'd0;
        for (int i = 0; i < MrgHw; i++) begin
            mrg[i] = 16'h0;
        end
        for (int i = 0; i < WinHw; i++) begin
            if (3'(i) < hw_cnt_q) begin
                mrg[i] = win_q[i];
            end
        end
        for (int i = 0; i < MrgHw; i++) begin
            src = 4'(i) - {1'b0, hw_cnt_q} + {2'b00, drop_q};
            if (pop && (4'(i) >= {1'b0, hw_cnt_q}) && (src <= 4'd3)) begin
                mrg[i] = buf_hw[src[1:0]];
            end
        end
    end

    assign mrg_cnt   = {1'b0, hw_cnt_q} + (pop ? (4'd4 - {2'b00, drop_q}) : 4'd0);
    assign mrg_rvc   = (mrg[0][1:0] != 2'b11);
    assign mrg_cmpl  = mrg_rvc ? (mrg_cnt >= 4'd1) : (mrg_cnt >= 4'd2);
    assign issue     = mrg_cmpl && out_free && !FlushValid;
    assign cons      = issue ? (mrg_rvc ? 2'd1 : 2'd2) : 2'd0;
    assign hw_cnt_nx = 3'(mrg_cnt - {2'b00, cons});
    assign inst_nx   = mrg_rvc ? {16'h0, mrg[0]} : {mrg[1], mrg[0]};

    always_comb begin
        for (int i = 0; i < WinHw; i++) begin
            case (cons)
                2'd1:    win_nx[i] = mrg[i+1];
                2'd2:    win_nx[i] = mrg[i+2];
                default: win_nx[i] = mrg[i];
            endcase
        end
    end

    // Control and output register. Flush outranks issue and pop.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            hw_cnt_q  <= 3'd0;
            drop_q    <= 2'd0;
            next_pc_q <= ResetPc;
            InstValid <= 1'b0;
            Inst      <= 32'h0;
            InstPc    <= '0;
            InstIsRvc <= 1'b0;
        end else if (FlushValid) begin
            hw_cnt_q  <= 3'd0;
            drop_q    <= FlushPc[2:1];
            next_pc_q <= {FlushPc[PcWidth-1:1], 1'b0};
            InstValid <= 1'b0;
        end else begin
            hw_cnt_q <= hw_cnt_nx;
            if (pop) begin
                drop_q <= 2'd0;
            end
            if (issue) begin
                InstValid <= 1'b1;
                Inst      <= inst_nx;
                InstIsRvc <= mrg_rvc;
                InstPc    <= next_pc_q;
                next_pc_q <= next_pc_q + (mrg_rvc ? PcWidth'(2) : PcWidth'(4));
            end else if (InstReady) begin
                InstValid <= 1'b0;
            end
        end
    end

    // Window data is qualified by hw_cnt_q and needs no reset.
    always_ff @(posedge Clk) begin
        win_q <= win_nx;
    end

endmodule

// File: tb/tb_instr_aligner.sv
module tb_instr_aligner;

    logic        clk;
    logic        rst;
    logic        buf_full;
    logic [63:0] buf_data;
    logic        buf_pop;
    logic        flush_valid;
    logic [63:0] flush_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_is_rvc;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] fq [$];
    logic [31:0] got_inst [$];
    logic [63:0] got_pc [$];
    logic        got_rvc [$];
    logic [31:0] exp_inst [$];
    logic [63:0] exp_pc [$];
    logic        exp_rvc [$];

    logic [15:0] t2_hw [4];

    instr_aligner dut (
        .Clk        (clk),
        .Rst        (rst),
        .BufFull    (buf_full),
        .BufData    (buf_data),
        .BufPop     (buf_pop),
        .FlushValid (flush_valid),
        .FlushPc    (flush_pc),
        .InstValid  (inst_valid),
        .InstReady  (inst_ready),
        .Inst       (inst),
        .InstPc     (inst_pc),
        .InstIsRvc  (inst_is_rvc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h required %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive_buf();
        buf_full = (fq.size() != 0);
        buf_data = (fq.size() != 0) ? fq[0] : 64'h0;
    endtask

    // Advance one clock. Decode acceptances and buffer pops are observed just
    // before the edge; inputs are refreshed 1 time unit after it.
    task automatic tick();
        logic popped;
        logic discard;
        popped  = buf_pop;
        discard = flush_valid && buf_full && !popped;
        if (inst_valid && inst_ready && !flush_valid && !rst) begin
            got_inst.push_back(inst);
            got_pc.push_back(inst_pc);
            got_rvc.push_back(inst_is_rvc);
        end
        @(posedge clk);
        #1;
        if ((popped || discard) && fq.size() != 0) begin
            void'(fq.pop_front());
        end
        drive_buf();
        #1;
    endtask

    task automatic push_word(input logic [63:0] w);
        fq.push_back(w);
        drive_buf();
        #1;
    endtask

    task automatic expect_inst(input logic [31:0] i, input logic [63:0] pc, input logic rvc);
        exp_inst.push_back(i);
        exp_pc.push_back(pc);
        exp_rvc.push_back(rvc);
    endtask

    task automatic clear_stream();
        got_inst.delete(); got_pc.delete(); got_rvc.delete();
        exp_inst.delete(); exp_pc.delete(); exp_rvc.delete();
    endtask

    task automatic compare_stream(input string tag);
        check({tag, ".count"}, 64'(got_inst.size()), 64'(exp_inst.size()));
        for (int k = 0; k < exp_inst.size() && k < got_inst.size(); k++) begin
            check($sformatf("%s.inst%0d", tag, k), 64'(got_inst[k]), 64'(exp_inst[k]));
            check($sformatf("%s.pc%0d", tag, k), got_pc[k], exp_pc[k]);
            check($sformatf("%s.rvc%0d", tag, k), 64'(got_rvc[k]), 64'(exp_rvc[k]));
        end
        clear_stream();
    endtask

    initial begin
        rst         = 1'b1;
        buf_full    = 1'b0;
        buf_data    = 64'h0;
        flush_valid = 1'b0;
        flush_pc    = 64'h0;
        inst_ready  = 1'b1;
        t2_hw       = '{16'h0001, 16'h0505, 16'h4501, 16'h0001};
        tick();
        tick();

        // Reset state, then two 32-bit instructions from one word
        push_word(64'h00100593_00000513);
        check("rst.pop",   64'(buf_pop),     64'd0);
        check("rst.valid", 64'(inst_valid),  64'd0);
        check("rst.inst",  64'(inst),        64'd0);
        check("rst.pc",    inst_pc,          64'd0);
        check("rst.rvc",   64'(inst_is_rvc), 64'd0);
        rst = 1'b0;
        #1;
        check("t1.pop",    64'(buf_pop),    64'd1);
        check("t1.valid0", 64'(inst_valid), 64'd0);
        tick();
        check("t1.valid1", 64'(inst_valid),  64'd1);
        check("t1.inst1",  64'(inst),        64'h0000_0513);
        check("t1.pc1",    inst_pc,          64'h8000_0000);
        check("t1.rvc1",   64'(inst_is_rvc), 64'd0);
        check("t1.nopop",  64'(buf_pop),     64'd0);
        tick();
        check("t1.inst2",  64'(inst),        64'h0010_0593);
        check("t1.pc2",    inst_pc,          64'h8000_0004);
        tick();
        check("t1.idle",   64'(inst_valid),  64'd0);

        // Four RVC instructions in one word, one per cycle
        push_word(64'h0001_4501_0505_0001);
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2.valid%0d", k), 64'(inst_valid),  64'd1);
            check($sformatf("t2.inst%0d", k),  64'(inst),        64'(t2_hw[k]));
            check($sformatf("t2.pc%0d", k),    inst_pc,          64'h8000_0008 + 64'(2 * k));
            check($sformatf("t2.rvc%0d", k),   64'(inst_is_rvc), 64'd1);
            tick();
        end
        check("t2.idle", 64'(inst_valid), 64'd0);

        // Straddling 32-bit instruction, after a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        clear_stream();
        push_word(64'h0513_4501_0505_0001);
        for (int k = 0; k < 4; k++) tick();
        check("t3.wait0", 64'(inst_valid), 64'd0);
        tick();
        check("t3.wait1", 64'(inst_valid), 64'd0);
        check("t3.nopop", 64'(buf_pop),    64'd0);
        push_word(64'h0001_0001_0001_0000);
        check("t3.pop",   64'(buf_pop),    64'd1);
        tick();
        check("t3.inst",  64'(inst),        64'h0000_0513);
        check("t3.pc",    inst_pc,          64'h8000_0006);
        check("t3.rvc",   64'(inst_is_rvc), 64'd0);
        for (int k = 0; k < 6; k++) tick();
        expect_inst(32'h0000_0001, 64'h8000_0000, 1'b1);
        expect_inst(32'h0000_0505, 64'h8000_0002, 1'b1);
        expect_inst(32'h0000_4501, 64'h8000_0004, 1'b1);
        expect_inst(32'h0000_0513, 64'h8000_0006, 1'b0);
        expect_inst(32'h0000_0001, 64'h8000_000A, 1'b1);
        expect_inst(32'h0000_0001, 64'h8000_000C, 1'b1);
        expect_inst(32'h0000_0001, 64'h8000_000E, 1'b1);
        compare_stream("t3");

        // Backpressure with a word waiting upstream
        push_word(64'h00200613_00100593);
        push_word(64'h00400713_00300693);
        push_word(64'h00600813_00500793);
        tick();
        tick();
        inst_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t4.valid%0d", k), 64'(inst_valid), 64'd1);
            check($sformatf("t4.inst%0d", k),  64'(inst),       64'h0020_0613);
            check($sformatf("t4.pc%0d", k),    inst_pc,         64'h8000_0014);
            check($sformatf("t4.pop%0d", k),   64'(buf_pop),    64'd0);
            tick();
        end
        inst_ready = 1'b1;
        #1;
        for (int k = 0; k < 7; k++) tick();
        expect_inst(32'h0010_0593, 64'h8000_0010, 1'b0);
        expect_inst(32'h0020_0613, 64'h8000_0014, 1'b0);
        expect_inst(32'h0030_0693, 64'h8000_0018, 1'b0);
        expect_inst(32'h0040_0713, 64'h8000_001C, 1'b0);
        expect_inst(32'h0050_0793, 64'h8000_0020, 1'b0);
        expect_inst(32'h0060_0813, 64'h8000_0024, 1'b0);
        compare_stream("t4");

        // Flush while an instruction is presented and a word is waiting
        push_word(64'h00800913_00700893);
        push_word(64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        check("t5.valid", 64'(inst_valid), 64'd1);
        check("t5.inst",  64'(inst),       64'h0070_0893);
        check("t5.pc",    inst_pc,         64'h8000_0028);
        flush_valid = 1'b1;
        flush_pc    = 64'h8000_1006;
        #1;
        check("t5.nopop", 64'(buf_pop), 64'd0);
        tick();
        flush_valid = 1'b0;
        #1;
        check("t5.killed", 64'(inst_valid), 64'd0);
        clear_stream();
        push_word(64'h4505_FFFF_FFFF_FFFF);
        push_word(64'h00A00A13_00900993);
        check("t5.pop", 64'(buf_pop), 64'd1);
        for (int k = 0; k < 6; k++) tick();
        expect_inst(32'h0000_4505, 64'h8000_1006, 1'b1);
        expect_inst(32'h0090_0993, 64'h8000_1008, 1'b0);
        expect_inst(32'h00A0_0A13, 64'h8000_100C, 1'b0);
        compare_stream("t5");

        // Reset mid-stream with three halfwords still in the window
        push_word(64'h0001_0001_0001_0001);
        tick();
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        fq.delete();
        drive_buf();
        #1;
        check("t6.valid", 64'(inst_valid),  64'd0);
        check("t6.inst",  64'(inst),        64'd0);
        check("t6.pc",    inst_pc,          64'd0);
        check("t6.rvc",   64'(inst_is_rvc), 64'd0);
        clear_stream();
        push_word(64'h00C00C13_00B00B93);
        for (int k = 0; k < 5; k++) tick();
        expect_inst(32'h00B0_0B93, 64'h8000_0000, 1'b0);
        expect_inst(32'h00C0_0C13, 64'h8000_0004, 1'b0);
        compare_stream("t6");

        // PC wrap-around after a redirect to the top of the address space
        flush_valid = 1'b1;
        flush_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        tick();
        flush_valid = 1'b0;
        #1;
        clear_stream();
        push_word(64'h4505_FFFF_FFFF_FFFF);
        push_word(64'h0001_0001_0001_4501);
        for (int k = 0; k < 8; k++) tick();
        expect_inst(32'h0000_4505, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        expect_inst(32'h0000_4501, 64'h0000_0000_0000_0000, 1'b1);
        expect_inst(32'h0000_0001, 64'h0000_0000_0000_0002, 1'b1);
        expect_inst(32'h0000_0001, 64'h0000_0000_0000_0004, 1'b1);
        expect_inst(32'h0000_0001, 64'h0000_0000_0000_0006, 1'b1);
        compare_stream("t7");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
